vga_glyph_capture: RTL and testbench
====================================

// Module: vga_glyph_capture
// PURPOSE
//  Receive end of the VGA glyph display link. Samples RGB and the active-high HSINC/VSINC
//  enables on the pixel clock, then measures active width and height and locks to a stable format.
//  On request, captures a 128x96 one-bit window of the next full frame into an internal bitmap.
//  The bitmap is read back one row at a time, for loopback checking of rendered HanZi.
// PARAMETERS
//  WIN_X0  335  first captured pixel index within the active line (0-based)
//  WIN_Y0  251  first captured line index within the active frame (0-based)
//  WIN_W   128  window width in pixels (fixed; equals row width of rd_data)
//  WIN_H   96   window height in lines
// PORTS
//  clk       in   1    pixel clock; all logic on posedge
//  reset     in   1    synchronous, active-low reset
//  rgb_in    in   3    pixel colour; pixel "on" = (rgb_in != 0)
//  hs_in     in   1    high while the current line is in its active pixel region
//  vs_in     in   1    high while the current frame is in its active line region
//  cap_req   in   1    one-cycle pulse: capture the next complete frame
//  cap_busy  out  1    high from accepted cap_req until cap_done
//  cap_done  out  1    one-cycle pulse when the capture ends
//  cap_err   out  1    valid with cap_done: 1 = lock lost, bitmap incomplete
//  locked    out  1    format stable (two consecutive frames match)
//  meas_w    out  11   active pixels per line of the last complete frame
//  meas_h    out  10   active lines of the last complete frame
//  rd_row    in   7    bitmap row select, 0..WIN_H-1
//  rd_data   out  128  bitmap row; bit 0 = leftmost pixel (WIN_X0)
// BEHAVIOUR
//  Reset (reset==0 at posedge): all outputs 0; FSMs to SEARCH/IDLE; counters 0; bitmap contents undefined.
//  Input registration:
//   - hs_in, vs_in and rgb_in are registered once.
//   - Edge detection uses the registered copies.
//  Counters:
//   - px = count of hs-high cycles in the current line; cleared on the hs falling edge.
//   - ln = hs falling edges seen while vs is high; cleared on the vs rising edge.
//   - Both counters saturate at their maximum value and do not wrap.
//  Frame end = vs falling edge.
//   - meas_h <= ln; meas_w <= width of the first line in the frame.
//   - A frame is "bad" if any line width differs from the first line, or ln==0.
//  Lock FSM:
//   - SEARCH -> MEASURE at the first frame end of a good frame; it stores W/H.
//   - MEASURE -> LOCKED at the next frame end if good and W/H equal the stored values; otherwise stay in MEASURE and re-store.
//   - LOCKED -> SEARCH at any frame end that is bad or mismatched.
//   - locked=1 only in LOCKED.
//  Capture FSM:
//   - IDLE: cap_req && locked -> ARMED, cap_busy=1. cap_req while not locked or busy is ignored.
//   - ARMED -> CAPTURE on the vs rising edge.
//   - CAPTURE: on each cycle with hs high, px in [WIN_X0, WIN_X0+127] and ln in [WIN_Y0, WIN_Y0+WIN_H-1], write bit (rgb!=0) to bitmap[ln-WIN_Y0][px-WIN_X0].
//   - CAPTURE -> IDLE at frame end: cap_done=1 and cap_busy=0 in the same cycle; cap_err=0.
//   - If locked drops at that frame end, the capture still terminates with cap_err=1.
//  Window bounds: a window outside the measured frame yields no writes. Capture still completes, cap_err=0, and unwritten bits are stale.
//  Read port: rd_data is registered, with 1-cycle latency from rd_row. rd_row >= WIN_H returns 0.
//  Simultaneous events:
//   - A same-cycle write and read of one row returns the old contents.
//   - A cap_req in the cycle of cap_done is ignored.
//  Reset mid-capture aborts with no cap_done pulse; locked returns to 0.
// TESTING
//  1. Stable frames, 805x603 active, 1040x666 total:
//     -> locked=1 after the 2nd frame end; meas_w=805, meas_h=603.
//  2. Locked; pulse cap_req; rgb=7 only at active x 335..462, lines 251..346:
//     -> cap_done after one full frame, cap_err=0; every rd_data row = all-ones.
//  3. Diagonal pattern with pixel (335+i, 251+i) on for i<96:
//     -> rd_row=i returns only bit i set, valid one cycle after rd_row.
//  4. Locked and capturing; the next frame has 604 lines:
//     -> at that frame end locked=0, cap_done=1, cap_err=1.
//  5. cap_req with locked=0, and a second cap_req while busy:
//     -> both ignored; exactly one cap_done for the accepted request.
//  6. reset=0 for one cycle mid-capture:
//     -> all outputs 0 next cycle, no cap_done; relock takes 2 frames.

Source files
------------

// File: rtl/vga_glyph_capture_if.sv
// vga_glyph_capture_if
//   Bundles the video inputs, capture handshake, format status and bitmap read
//   port of vga_glyph_capture. clk and reset stay as plain ports on the module.
//   master : video source / host side (drives rgb/hs/vs, cap_req, rd_row)
//   slave  : capture block side (drives status, handshake outputs, rd_data)
interface vga_glyph_capture_if;
  logic [2:0]   rgb_in;
  logic         hs_in;
  logic         vs_in;
  logic         cap_req;
  logic         cap_busy;
  logic         cap_done;
  logic         cap_err;
  logic         locked;
  logic [10:0]  meas_w;
  logic [9:0]   meas_h;
  logic [6:0]   rd_row;
  logic [127:0] rd_data;

  modport master (
    output rgb_in, hs_in, vs_in, cap_req, rd_row,
    input  cap_busy, cap_done, cap_err, locked, meas_w, meas_h, rd_data
  );

  modport slave (
    input  rgb_in, hs_in, vs_in, cap_req, rd_row,
    output cap_busy, cap_done, cap_err, locked, meas_w, meas_h, rd_data
  );
endinterface

// File: rtl/vga_glyph_capture.sv
// vga_glyph_capture
//   Receive end of the VGA glyph link. Registers RGB/HS/VS, measures active
//   width/height per frame, locks once two consecutive good frames agree, and
//   on request captures a WIN_W x WIN_H one-bit window of the next frame into
//   an internal bitmap that is read back one row per access.
// Ports
//   clk    : pixel clock, all logic on posedge
//   reset  : synchronous active-low reset
//   bus    : slave modport of vga_glyph_capture_if
//            (rgb_in/hs_in/vs_in video, cap_req/cap_busy/cap_done/cap_err
//             handshake, locked/meas_w/meas_h status, rd_row/rd_data read port)
//
// Lock FSM
//   state     | meaning
//   L_SEARCH  | no reference format, waiting for a good frame
//   L_MEASURE | reference W/H stored, waiting for a matching frame
//   L_LOCKED  | format stable, locked=1
// Capture FSM
//   state     | meaning
//   C_IDLE    | no capture pending
//   C_ARMED   | request accepted, waiting for next frame start
//   C_CAPTURE | writing window pixels until frame end
module vga_glyph_capture #(
  parameter int WIN_X0 = 335,
  parameter int WIN_Y0 = 251,
  parameter int WIN_W  = 128,
  parameter int WIN_H  = 96
) (
  input  logic clk,
  input  logic reset,
  vga_glyph_capture_if.slave bus
);

  localparam int AW = $clog2(WIN_H);
  localparam logic [10:0] X_LO = 11'(WIN_X0);
  localparam logic [10:0] X_HI = 11'(WIN_X0 + WIN_W - 1);
  localparam logic [9:0]  Y_LO = 10'(WIN_Y0);
  localparam logic [9:0]  Y_HI = 10'(WIN_Y0 + WIN_H - 1);

  typedef enum logic [1:0] {L_SEARCH, L_MEASURE, L_LOCKED} lock_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ARMED, C_CAPTURE} cap_state_t;

  logic        hs_r, vs_r, hs_d, vs_d;
  logic [2:0]  rgb_r;
  logic [10:0] px;
  logic [9:0]  ln;
  logic [10:0] first_w;
  logic        width_bad;

  lock_state_t lk;
  logic [10:0] ref_w;
  logic [9:0]  ref_h;
  logic        locked_q;
  logic [10:0] meas_w_q;
  logic [9:0]  meas_h_q;

  cap_state_t  cs;
  logic        busy_q, done_q, err_q;

  logic [127:0] bitmap [0:WIN_H-1];
  logic [127:0] rd_q;

  logic        hs_fall, vs_rise, vs_fall;
  logic        frame_good, frame_match, lock_hold;
  logic [9:0]  ln_cur;
  logic        wr_en;
  logic [6:0]  row, col;

  assign hs_fall = hs_d & ~hs_r;
  assign vs_rise = vs_r & ~vs_d;
  assign vs_fall = vs_d & ~vs_r;

  assign frame_good  = !width_bad && (ln != '0);
  assign frame_match = frame_good && (first_w == ref_w) && (ln == ref_h);
  // Lock survives this frame end only if already locked and the frame agrees.
  assign lock_hold   = (lk == L_LOCKED) && frame_match;

  // ln is cleared by the vs rising edge one cycle late; treat that cycle as line 0.
  assign ln_cur = vs_rise ? '0 : ln;
  assign wr_en  = ((cs == C_CAPTURE) || (cs == C_ARMED && vs_rise)) &&
                  hs_r && vs_r &&
                  (px >= X_LO) && (px <= X_HI) &&
                  (ln_cur >= Y_LO) && (ln_cur <= Y_HI);
  // Modular subtraction on the low bits is exact inside the window.
  assign row = ln_cur[6:0] - Y_LO[6:0];
  assign col = px[6:0] - X_LO[6:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      rgb_r     <= '0;
      px        <= '0;
      ln        <= '0;
      first_w   <= '0;
      width_bad <= 1'b0;
    end else begin
      hs_r  <= bus.hs_in;
      vs_r  <= bus.vs_in;
      rgb_r <= bus.rgb_in;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      if (hs_fall)
        px <= '0;
      else if (hs_r && px != '1)
        px <= px + 11'd1;
      if (vs_rise) begin
        ln        <= '0;
        first_w   <= '0;
        width_bad <= 1'b0;
      end else if (hs_fall && vs_r) begin
        if (ln != '1)
          ln <= ln + 10'd1;
        if (ln == '0)
          first_w <= px;
        else if (px != first_w)
          width_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lk       <= L_SEARCH;
      ref_w    <= '0;
      ref_h    <= '0;
      locked_q <= 1'b0;
      meas_w_q <= '0;
      meas_h_q <= '0;
    end else if (vs_fall) begin
      meas_w_q <= first_w;
      meas_h_q <= ln;
      case (lk)
        L_SEARCH: begin
          if (frame_good) begin
            lk    <= L_MEASURE;
            ref_w <= first_w;
            ref_h <= ln;
          end
        end
        L_MEASURE: begin
          if (frame_match) begin
            lk       <= L_LOCKED;
            locked_q <= 1'b1;
          end else begin
            ref_w <= first_w;
            ref_h <= ln;
          end
        end
        L_LOCKED: begin
          if (!frame_match) begin
            lk       <= L_SEARCH;
            locked_q <= 1'b0;
          end
        end
        default: begin
          lk       <= L_SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs     <= C_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (cs)
        C_IDLE: begin
          // done_q blocks a request landing in the same cycle as cap_done.
          if (bus.cap_req && locked_q && !done_q) begin
            cs     <= C_ARMED;
            busy_q <= 1'b1;
          end
        end
        C_ARMED: begin
          // Lock lost before the captured frame even started: finish with error.
          if (vs_fall && !lock_hold) begin
            cs     <= C_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (vs_rise) begin
            cs <= C_CAPTURE;
          end
        end
        C_CAPTURE: begin
          if (vs_fall) begin
            cs     <= C_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= !lock_hold;
          end
        end
        default: begin
          cs     <= C_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Bitmap storage has no reset; contents are undefined until captured.
  always_ff @(posedge clk) begin
    if (wr_en)
      bitmap[row[AW-1:0]][col] <= |rgb_r;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      rd_q <= '0;
    else if ({1'b0, bus.rd_row} < 8'(WIN_H))
      rd_q <= bitmap[bus.rd_row[AW-1:0]];
    else
      rd_q <= '0;
  end

  assign bus.locked   = locked_q;
  assign bus.meas_w   = meas_w_q;
  assign bus.meas_h   = meas_h_q;
  assign bus.cap_busy = busy_q;
  assign bus.cap_done = done_q;
  assign bus.cap_err  = err_q;
  assign bus.rd_data  = rd_q;

endmodule

// File: tb/tb_vga_glyph_capture.sv
// Directed bench for vga_glyph_capture. The frame and window are scaled down
// (140x12 active, 150x14 total, 128x8 window at (5,2)) so that a dozen
// frames stay short; all behaviours are the same as at full size.
module tb_vga_glyph_capture;
  localparam int X0  = 5;
  localparam int Y0  = 2;
  localparam int WH  = 8;
  localparam int AW_ = 140;
  localparam int AH_ = 12;
  localparam int HBL = 10;
  localparam int VBL = 300;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   done_cnt;
  logic done_now;
  logic err_at_done;
  logic lock_at_done;
  logic [127:0] rst_snap;

  vga_glyph_capture_if bus ();

  vga_glyph_capture #(.WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(128), .WIN_H(WH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    done_now = bus.cap_done;
    if (bus.cap_done) begin
      done_cnt++;
      err_at_done  = bus.cap_err;
      lock_at_done = bus.locked;
    end
  endtask

  function automatic logic [2:0] pix(input int pat, input int x, input int y);
    logic [2:0] p;
    p = 3'd0;
    case (pat)
      1: if (x >= X0 && x < X0 + 128 && y >= Y0 && y < Y0 + WH) p = 3'd7;
      2: if (y >= Y0 && y < Y0 + WH &&
             (x == X0 + y - Y0 || x == X0 - 1 || x == X0 + 128)) p = 3'd5;
      default: p = 3'd0;
    endcase
    return p;
  endfunction

  // One full frame followed by vertical blanking. Optionally answers a
  // cap_done with a same-cycle cap_req, and optionally pulses reset.
  task automatic frame(input int w, input int h, input int pat,
                       input bit req_on_done, input int rst_at);
    int cyc;
    cyc = 0;
    done_cnt = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w + HBL; x++) begin
        bus.vs_in   = 1'b1;
        bus.hs_in   = (x < w);
        bus.rgb_in  = (x < w) ? pix(pat, x, y) : 3'd0;
        bus.cap_req = req_on_done && done_now;
        reset       = (cyc == rst_at) ? 1'b0 : 1'b1;
        tick();
        if (cyc == rst_at)
          rst_snap = {bus.rd_data[127:24], bus.locked, bus.cap_busy, bus.cap_done,
                      bus.cap_err, bus.meas_w, bus.meas_h} | 128'(bus.rd_data[23:0]);
        cyc++;
      end
    end
    for (int i = 0; i < VBL; i++) begin
      bus.vs_in   = 1'b0;
      bus.hs_in   = 1'b0;
      bus.rgb_in  = 3'd0;
      bus.cap_req = req_on_done && done_now;
      reset       = 1'b1;
      tick();
    end
    bus.cap_req = 1'b0;
  endtask

  task automatic pulse_req();
    bus.cap_req = 1'b1;
    tick();
    bus.cap_req = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; done_now = 1'b0;
    err_at_done = 1'b0; lock_at_done = 1'b0; rst_snap = '0;
    reset = 1'b0;
    bus.rgb_in = 3'd0; bus.hs_in = 1'b0; bus.vs_in = 1'b0;
    bus.cap_req = 1'b0; bus.rd_row = 7'd0;
    repeat (3) tick();
    check("rst_locked", bus.locked, 1'b0);
    check("rst_busy",   bus.cap_busy, 1'b0);
    check("rst_done",   bus.cap_done, 1'b0);
    check("rst_err",    bus.cap_err, 1'b0);
    check("rst_meas_w", bus.meas_w, 11'd0);
    check("rst_meas_h", bus.meas_h, 10'd0);
    check("rst_rd",     bus.rd_data, 128'd0);
    reset = 1'b1;
    tick();

    // request while unlocked is ignored
    pulse_req();
    check("req_unlocked_busy", bus.cap_busy, 1'b0);

    // lock acquisition
    frame(AW_, AH_, 0, 1'b0, -1);
    check("f1_locked", bus.locked, 1'b0);
    check("f1_meas_w", bus.meas_w, 11'd140);
    check("f1_meas_h", bus.meas_h, 10'd12);
    frame(AW_, AH_, 0, 1'b0, -1);
    check("f2_locked", bus.locked, 1'b1);
    check("f2_meas_w", bus.meas_w, 11'd140);
    check("f2_meas_h", bus.meas_h, 10'd12);

    // block capture, second request while busy ignored
    pulse_req();
    check("req_busy", bus.cap_busy, 1'b1);
    pulse_req();
    frame(AW_, AH_, 1, 1'b0, -1);
    check("blk_done_cnt", done_cnt, 1);
    check("blk_err", err_at_done, 1'b0);
    check("blk_lock_at_done", lock_at_done, 1'b1);
    check("blk_busy_after", bus.cap_busy, 1'b0);
    frame(AW_, AH_, 0, 1'b0, -1);
    check("no_second_capture", done_cnt, 0);
    for (int r = 0; r < WH; r++) begin
      bus.rd_row = 7'(r);
      tick();
      check($sformatf("blk_row%0d", r), bus.rd_data, {128{1'b1}});
    end
    bus.rd_row = 7'd8;
    tick();
    check("rd_row_8", bus.rd_data, 128'd0);
    bus.rd_row = 7'd127;
    tick();
    check("rd_row_127", bus.rd_data, 128'd0);

    // diagonal capture with on-pixels just outside the window columns;
    // cap_req in the cap_done cycle is ignored
    bus.rd_row = 7'd0;
    pulse_req();
    frame(AW_, AH_, 2, 1'b1, -1);
    check("diag_done_cnt", done_cnt, 1);
    check("diag_err", err_at_done, 1'b0);
    check("req_on_done_busy", bus.cap_busy, 1'b0);
    for (int i = 0; i < WH; i++) begin
      bus.rd_row = 7'(i);
      #1;
      if (i > 0) check($sformatf("diag_latency%0d", i), bus.rd_data, 128'd1 << (i - 1));
      tick();
      check($sformatf("diag_row%0d", i), bus.rd_data, 128'd1 << i);
    end
    bus.rd_row = 7'd0;

    // lock lost during capture: 13-line frame
    pulse_req();
    frame(AW_, AH_ + 1, 0, 1'b0, -1);
    check("lost_done_cnt", done_cnt, 1);
    check("lost_err", err_at_done, 1'b1);
    check("lost_lock_at_done", lock_at_done, 1'b0);
    check("lost_meas_h", bus.meas_h, 10'd13);
    pulse_req();
    check("req_after_lost_busy", bus.cap_busy, 1'b0);

    // relock, then reset mid-capture
    frame(AW_, AH_, 0, 1'b0, -1);
    check("re1_locked", bus.locked, 1'b0);
    frame(AW_, AH_, 0, 1'b0, -1);
    check("re2_locked", bus.locked, 1'b1);
    pulse_req();
    check("rst_cap_busy", bus.cap_busy, 1'b1);
    frame(AW_, AH_, 1, 1'b0, 4 * (AW_ + HBL) + 50);
    check("midrst_outputs", rst_snap, 128'd0);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_locked", bus.locked, 1'b0);
    frame(AW_, AH_, 0, 1'b0, -1);
    check("post1_locked", bus.locked, 1'b0);
    frame(AW_, AH_, 0, 1'b0, -1);
    check("post2_locked", bus.locked, 1'b1);
    check("post2_meas_w", bus.meas_w, 11'd140);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
